challenge_expand: RTL and testbench

Expands the 256-bit challenge digest into the Picnic challenge lists, downstream of the round-commitment stage that produces `Ch` and `Cv`.
- Challenge digest computed externally from `Ch`, `Cv`, salt, public key and message.
- Outputs `TAU` distinct opened-round indices (list C) and `TAU` unopened-party indices (list P).
- Bits are consumed MSB-first with rejection sampling; fresh digests are requested from the hash core when bits run out.
- Feeds the proof-assembly stage.

---
 rtl/picnic_params_pkg.sv | 20 ++
 rtl/challenge_expand_if.sv | 23 ++
 rtl/challenge_expand.sv | 131 +++++++++++++
 tb/tb_challenge_expand.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/picnic_params_pkg.sv
// Picnic parameter set shared by the round-commitment, hash-wrapper and
// challenge-expansion stages.
package picnic_params_pkg;
   localparam int NUM_ROUNDS  = 250;
   localparam int NUM_OPENED  = 36;
   localparam int NUM_PARTIES = 16;
   localparam int DIGEST_BITS = 256;
   localparam int ROUND_BITS  = $clog2(NUM_ROUNDS);
   localparam int PARTY_BITS  = $clog2(NUM_PARTIES);
   localparam int CNT_W       = $clog2(NUM_OPENED + 1);
   localparam int POS_W       = $clog2(DIGEST_BITS + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ROUNDS,
      ST_PARTIES,
      ST_REFILL,
      ST_DONE
   } state_e;
endpackage

// File: rtl/challenge_expand_if.sv
// Start/digest handshake and challenge-list bus of the challenge expander.
interface challenge_expand_if;
   import picnic_params_pkg::*;

   logic                                expand_start;
   logic [DIGEST_BITS-1:0]              digest_in;
   logic                                digest_req;
   logic                                digest_valid;
   logic [DIGEST_BITS-1:0]              digest_next;
   logic [NUM_OPENED*ROUND_BITS-1:0]    challenge_c;
   logic [NUM_OPENED*PARTY_BITS-1:0]    challenge_p;
   logic                                expand_end;

   modport master (
      output expand_start, digest_in, digest_valid, digest_next,
      input  digest_req, challenge_c, challenge_p, expand_end
   );

   modport slave (
      input  expand_start, digest_in, digest_valid, digest_next,
      output digest_req, challenge_c, challenge_p, expand_end
   );
endinterface

// File: rtl/challenge_expand.sv
// Expands a challenge digest into TAU distinct round indices (list C) and
// TAU party indices (list P), rejection-sampling MSB-first chunks.
module challenge_expand
   import picnic_params_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   challenge_expand_if.slave ch
);
   state_e                                 state_q, state_d;
   state_e                                 ret_q, ret_d;
   logic [DIGEST_BITS-1:0]                 sh_q, sh_d;
   logic [POS_W-1:0]                       pos_q, pos_d;
   logic [CNT_W-1:0]                       cnt_q, cnt_d;
   logic [NUM_ROUNDS-1:0]                  bmap_q, bmap_d;
   logic [NUM_OPENED-1:0][ROUND_BITS-1:0]  c_q, c_d;
   logic [NUM_OPENED-1:0][PARTY_BITS-1:0]  p_q, p_d;

   logic [ROUND_BITS-1:0] rchunk;
   logic [PARTY_BITS-1:0] pchunk;
   logic [POS_W-1:0]      pos_r, pos_p;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  r_acc, cnt_full, r_empty, p_empty;

   // The digest is kept as a left-shifting register so the next chunk is
   // always its top bits; pos only tracks exhaustion.
   assign rchunk   = sh_q[DIGEST_BITS-1 -: ROUND_BITS];
   assign pchunk   = sh_q[DIGEST_BITS-1 -: PARTY_BITS];
   assign pos_r    = pos_q + POS_W'(ROUND_BITS);
   assign pos_p    = pos_q + POS_W'(PARTY_BITS);
   assign cnt_inc  = cnt_q + CNT_W'(1);
   assign cnt_full = (cnt_inc == CNT_W'(NUM_OPENED));
   assign r_empty  = (pos_r == POS_W'(DIGEST_BITS));
   assign p_empty  = (pos_p == POS_W'(DIGEST_BITS));
   assign r_acc    = (32'(rchunk) < NUM_ROUNDS) && !bmap_q[rchunk];

   always_comb begin
      state_d = state_q;
      ret_d   = ret_q;
      sh_d    = sh_q;
      pos_d   = pos_q;
      cnt_d   = cnt_q;
      bmap_d  = bmap_q;
      c_d     = c_q;
      p_d     = p_q;
      case (state_q)
         ST_IDLE: begin
            if (ch.expand_start) begin
               sh_d    = ch.digest_in;
               pos_d   = '0;
               cnt_d   = '0;
               bmap_d  = '0;
               state_d = ST_ROUNDS;
            end
         end
         ST_ROUNDS: begin
            sh_d  = sh_q << ROUND_BITS;
            pos_d = pos_r;
            if (r_acc) begin
               c_d[cnt_q]     = rchunk;
               bmap_d[rchunk] = 1'b1;
               cnt_d          = cnt_inc;
            end
            // A list completed on the last chunk still needs fresh bits
            // for the party phase, so that refill returns to PARTIES.
            if (r_acc && cnt_full) begin
               cnt_d = '0;
               if (r_empty) begin
                  state_d = ST_REFILL;
                  ret_d   = ST_PARTIES;
               end else begin
                  state_d = ST_PARTIES;
               end
            end else if (r_empty) begin
               state_d = ST_REFILL;
               ret_d   = ST_ROUNDS;
            end
         end
         ST_PARTIES: begin
            sh_d       = sh_q << PARTY_BITS;
            pos_d      = pos_p;
            p_d[cnt_q] = pchunk;
            cnt_d      = cnt_inc;
            if (cnt_full) begin
               state_d = ST_DONE;
            end else if (p_empty) begin
               state_d = ST_REFILL;
               ret_d   = ST_PARTIES;
            end
         end
         ST_REFILL: begin
            if (ch.digest_valid) begin
               sh_d    = ch.digest_next;
               pos_d   = '0;
               state_d = ret_q;
            end
         end
         ST_DONE: ;
         default: state_d = ST_IDLE;
      endcase
      // Releasing start ends or aborts whatever is in flight.
      if (!ch.expand_start && state_q != ST_IDLE) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ret_q   <= ST_ROUNDS;
         sh_q    <= '0;
         pos_q   <= '0;
         cnt_q   <= '0;
         bmap_q  <= '0;
         c_q     <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         ret_q   <= ret_d;
         sh_q    <= sh_d;
         pos_q   <= pos_d;
         cnt_q   <= cnt_d;
         bmap_q  <= bmap_d;
         c_q     <= c_d;
         p_q     <= p_d;
      end
   end

   assign ch.digest_req  = (state_q == ST_REFILL);
   assign ch.expand_end  = (state_q == ST_DONE);
   assign ch.challenge_c = c_q;
   assign ch.challenge_p = p_q;
endmodule

// File: tb/tb_challenge_expand.sv
// Randomized bench for challenge_expand; expected lists come from a
// bitstream model over the sequence of supplied digests.
module tb_challenge_expand;
   import picnic_params_pkg::*;

   localparam int NDIG = 12;

   logic clk;
   logic reset;
   challenge_expand_if ifc();

   challenge_expand dut (.clk(clk), .reset(reset), .ch(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_fail;
   logic [255:0] dq [NDIG];
   logic [7:0]   ec [NUM_OPENED];
   logic [3:0]   ep [NUM_OPENED];
   int           eref;
   int           done_cyc, nref, first_req, req_hi;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] getbits(input int b, input int w);
      logic [255:0] d;
      if (b / 256 >= NDIG) return 8'h00;
      d = dq[b / 256] >> (256 - w - (b % 256));
      return (w == 8) ? d[7:0] : {4'h0, d[3:0]};
   endfunction

   // Treat the digests as one continuous bitstream; refills = index of the
   // digest holding the last consumed bit.
   task automatic model();
      bit seen [256];
      int b, k;
      logic [7:0] v;
      for (int i = 0; i < 256; i++) seen[i] = 1'b0;
      b = 0; k = 0;
      while (k < NUM_OPENED && b < NDIG * 256) begin
         v = getbits(b, 8); b += 8;
         if (int'(v) < NUM_ROUNDS && !seen[v]) begin
            ec[k] = v; seen[v] = 1'b1; k++;
         end
      end
      for (k = 0; k < NUM_OPENED; k++) begin
         v = getbits(b, 4); ep[k] = v[3:0]; b += 4;
      end
      eref = (b - 1) / 256;
   endtask

   function automatic logic [255:0] rand_digest();
      logic [255:0] d;
      int r;
      for (int j = 0; j < 32; j++) begin
         r = $urandom_range(0, 9);
         d[255-8*j -: 8] = (r < 3) ? 8'($urandom_range(250, 255)) :
                           (r < 6) ? 8'($urandom_range(0, 47)) : 8'($urandom_range(0, 255));
      end
      return d;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < NDIG; i++) dq[i] = rand_digest();
   endtask

   task automatic run_exp(input int fix_dly, input bit noise);
      int nd, wcnt, dly;
      nd = 1; wcnt = 0; dly = -1;
      done_cyc = 0; nref = 0; first_req = 0; req_hi = 0;
      ifc.digest_in    = dq[0];
      ifc.expand_start = 1'b1;
      for (int cyc = 1; cyc <= 3000 && done_cyc == 0; cyc++) begin
         @(negedge clk);
         ifc.digest_valid = 1'b0;
         if (ifc.expand_end) begin
            done_cyc = cyc;
         end else if (ifc.digest_req) begin
            req_hi++;
            if (first_req == 0) first_req = cyc;
            if (dly < 0) dly = (fix_dly >= 0) ? fix_dly : int'($urandom_range(0, 4));
            if (wcnt >= dly) begin
               ifc.digest_valid = 1'b1;
               ifc.digest_next  = (nd < NDIG) ? dq[nd] : '0;
               nd++; nref++; wcnt = 0; dly = -1;
            end else begin
               wcnt++;
            end
         end else if (noise && $urandom_range(0, 3) == 0) begin
            ifc.digest_valid = 1'b1;
            ifc.digest_next  = {8{$urandom()}};
         end
      end
      ifc.digest_valid = 1'b0;
      if (done_cyc == 0) chk("timeout_end", 0, 1);
   endtask

   task automatic verify_lists(input string name);
      for (int i = 0; i < NUM_OPENED; i++) begin
         chk($sformatf("%s_c%0d", name, i), 64'(ifc.challenge_c[8*i +: 8]), 64'(ec[i]));
         chk($sformatf("%s_p%0d", name, i), 64'(ifc.challenge_p[4*i +: 4]), 64'(ep[i]));
      end
      chk({name, "_refills"}, nref, eref);
   endtask

   task automatic finish_exp(input string name);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk({name, "_hold_end"}, ifc.expand_end, 1);
         chk({name, "_hold_req"}, ifc.digest_req, 0);
      end
      verify_lists(name);
      ifc.expand_start = 1'b0;
      @(negedge clk);
      chk({name, "_drop_end"}, ifc.expand_end, 0);
      @(negedge clk);
   endtask

   task automatic build_directed();
      byte unsigned hdr [7];
      hdr = '{8'hFF, 8'hFA, 8'h20, 8'h20, 8'h21, 8'h22, 8'h23};
      for (int j = 0; j < 32; j++) dq[0][255-8*j -: 8] = 8'(j);
      for (int j = 0; j < 32; j++)
         dq[1][255-8*j -: 8] = (j < 7) ? hdr[j] : 8'((j * 37 + 5) & 255);
      for (int i = 2; i < NDIG; i++) dq[i] = rand_digest();
   endtask

   initial begin
      n_chk = 0; n_fail = 0;
      reset = 1'b0;
      ifc.expand_start = 1'b0;
      ifc.digest_in    = '0;
      ifc.digest_valid = 1'b0;
      ifc.digest_next  = '0;

      @(negedge clk);
      chk("rst_req", ifc.digest_req, 0);
      chk("rst_end", ifc.expand_end, 0);
      chk("rst_c", 64'(|ifc.challenge_c), 0);
      chk("rst_p", 64'(|ifc.challenge_p), 0);
      reset = 1'b1;
      ifc.digest_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_req", ifc.digest_req, 0);
         chk("idle_end", ifc.expand_end, 0);
      end
      ifc.digest_valid = 1'b0;

      // Bytes 0..31 then FF FA 20 20 21 22 23 ...; immediate refill.
      build_directed(); model();
      run_exp(0, 1'b0);
      chk("dir_latency", done_cyc, 77);
      chk("dir_first_req", first_req, 33);
      chk("dir_refills", nref, 1);
      chk("dir_c32", 64'(ifc.challenge_c[8*32 +: 8]), 8'h20);
      chk("dir_c35", 64'(ifc.challenge_c[8*35 +: 8]), 8'h23);
      chk("dir_p0", 64'(ifc.challenge_p[3:0]), 64'(dq[1][255-56 -: 4]));
      finish_exp("dir");

      // Same digests with the refill answer withheld for 10 cycles.
      run_exp(10, 1'b0);
      chk("dly_latency", done_cyc, 87);
      chk("dly_req_cycles", req_hi, 11);
      finish_exp("dly");

      // First digest yields nothing.
      for (int i = 0; i < NDIG; i++) dq[i] = rand_digest();
      dq[0] = '1;
      model();
      run_exp(-1, 1'b1);
      chk("ff_first_req", first_req, 33);
      finish_exp("ff");

      // Abort mid-ROUNDS, then a fresh run must not see stale bitmap state.
      fill_random();
      ifc.digest_in = dq[0]; ifc.expand_start = 1'b1;
      repeat (10) @(negedge clk);
      ifc.expand_start = 1'b0;
      @(negedge clk);
      chk("abort_req", ifc.digest_req, 0);
      chk("abort_end", ifc.expand_end, 0);
      @(negedge clk);
      fill_random(); model();
      run_exp(-1, 1'b1);
      finish_exp("post_abort");

      for (int t = 0; t < 20; t++) begin
         fill_random(); model();
         run_exp(-1, 1'b1);
         finish_exp($sformatf("rnd%0d", t));
      end

      // Reset in the middle of ROUNDS clears everything immediately.
      fill_random();
      ifc.digest_in = dq[0]; ifc.expand_start = 1'b1;
      repeat (12) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_c", 64'(|ifc.challenge_c), 0);
      chk("mid_rst_p", 64'(|ifc.challenge_p), 0);
      chk("mid_rst_req", ifc.digest_req, 0);
      chk("mid_rst_end", ifc.expand_end, 0);
      ifc.expand_start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_req", ifc.digest_req, 0);
         chk("post_rst_c", 64'(|ifc.challenge_c), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
